id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register feeding the ALU. It latches decoded instruction fields and resolves operand forwarding from the two later stages. It also detects load-use hazards, inserting a bubble and back-pressuring decode, and honours branch flush. Its operand and opcode outputs drive the ALU inputs directly; the ALU's registered result returns as the MEM-stage forwarding source.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of saturating stall/flush counters

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  decode presents an instruction
- ready_o  out  1  stage accepts input this cycle (combinational)
- flush_i  in  1  branch redirect: discard held and incoming instruction
- pc_i, imm_i, rs1_data_i, rs2_data_i  in  XLEN  decoded values; register-file read data
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5  register indices
- alu_op_i  in  4  ALU opcode, encoded per pipeline_pkg
- op_a_sel_i  in  1  0 = rs1, 1 = pc
- op_b_sel_i  in  1  0 = rs2, 1 = imm
- rd_wren_i, mem_rden_i  in  1  writes rd; is a load
- mem_rd_addr_i, mem_rd_wren_i, mem_data_i  in  5/1/XLEN  MEM-stage forward source (ALU result)
- wb_rd_addr_i, wb_rd_wren_i, wb_data_i  in  5/1/XLEN  WB-stage forward source
- valid_o  out  1  held instruction is real
- openrand_a_o, openrand_b_o  out  XLEN  ALU operands
- alu_op_o  out  4  ALU opcode
- store_data_o  out  XLEN  forwarded rs2 for stores
- pc_o  out  XLEN;  rd_addr_o  out  5
- rd_wren_o, mem_rden_o  out  1  gated by valid_o
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

## Operation
- Held state: valid, pc, imm, rs1/rs2 data and addresses, rd, alu_op, selects, rd_wren, mem_rden.
- Hazard (combinational) when: held valid AND held mem_rden AND held rd ≠ 0 AND valid_i AND (rs1_addr_i == held rd OR rs2_addr_i == held rd).
  - A source index that the decoded instruction does not use may still match. The resulting conservative stall is accepted.
- ready_o = ~hazard.
- Register update priority, per cycle:
  1. rst_i: all held fields 0, valid 0, counters 0.
  2. flush_i: valid ← 0, other fields don't-care. flush_cnt increments.
  3. hazard: valid ← 0 (bubble). Upstream holds its instruction. stall_cnt increments.
  4. Otherwise: load all fields; valid ← valid_i.
- Counters saturate at all-ones; no wrap.
- Forwarding, applied per source (rs1, rs2) on held values:
  - MEM match (mem_rd_wren_i, addr ≠ 0, addr equal) takes priority over WB match.
  - WB match is used next; otherwise the held register-file data.
  - Index 0 is never forwarded.
- openrand_a_o = op_a_sel ? pc : fwd_rs1.
- openrand_b_o = op_b_sel ? imm : fwd_rs2.
- store_data_o = fwd_rs2.
- alu_op_o = valid ? held alu_op : 4'b0000 (ADD).
- rd_wren_o and mem_rden_o are 0 when valid_o = 0.

## Timing
- Latency: input accepted at edge n appears on outputs in cycle n+1. The ALU result is available at edge n+2.
- Forwarding is combinational within the held cycle, matching the ALU's registered-output timing (MEM = ALU result of the previous instruction).
- Reset values: valid_o 0, every data output 0, alu_op_o 0000, counters 0.
- Load-use costs exactly one bubble. The next cycle the load is in MEM, the hazard clears, and the consumer takes its operand from the WB path.
- flush_i together with a hazard: flush wins. Only flush_cnt increments.
- Reset asserted mid-stall: reset takes priority. ready_o returns to 1 the next cycle.

## Structure
- pipeline_pkg holds:
  - alu_op_e: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
  - XLEN default, REG_ZERO constant.
  - id_ex_t struct for the held fields.
- One sub-module, fwd_mux: 2-source priority forward selector, instantiated twice (rs1, rs2).

## Test plan
- Reset, then feed ADD, rs1 = 5 (data 3), rs2 = 6 (data 4), no forward → next cycle openrand_a_o = 3, openrand_b_o = 4, alu_op_o = 0000, valid_o = 1.
- MEM and WB both write x5, with mem_data_i = 0xAA and wb_data_i = 0xBB, while held rs1 = 5 → openrand_a_o = 0xAA. Repeat with rd = 0 → register-file data is used.
- Held load rd = 7, incoming valid rs2 = 7 → ready_o = 0 for one cycle. Next cycle valid_o = 0 and stall_cnt_o = 1, then the consumer enters.
- Hazard plus flush_i in the same cycle → valid_o = 0 next cycle, flush_cnt_o = 1, stall_cnt_o unchanged.
- op_a_sel = 1, pc = 0x100; op_b_sel = 1, imm = 0xFFFFFFFC; SUB → openrand_a_o = 0x100, openrand_b_o = 0xFFFFFFFC, alu_op_o = 1000.
- Force 2^CNT_W + 3 stall cycles → stall_cnt_o holds 0xFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALU opcode encoding, register-index constants and the
// ID/EX held-instruction payload.
package pipeline_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 4;

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // Decoded instruction as held between decode and execute.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [REG_W-1:0] rs1_addr;
    logic [REG_W-1:0] rs2_addr;
    logic [REG_W-1:0] rd_addr;
    alu_op_e          alu_op;
    logic             op_a_sel;
    logic             op_b_sel;
    logic             rd_wren;
    logic             mem_rden;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Two-source priority forward selector for one register operand.
// Ports: src_addr/rf_data    - operand index and register-file read data
//        mem_*               - MEM-stage write-back candidate (higher priority)
//        wb_*                - WB-stage write-back candidate
//        data_c              - resolved operand (combinational)
module fwd_mux
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = pipeline_pkg::XLEN
) (
  input  logic [REG_W-1:0] src_addr,
  input  logic [XLEN-1:0]  rf_data,
  input  logic [REG_W-1:0] mem_addr,
  input  logic             mem_wren,
  input  logic [XLEN-1:0]  mem_data,
  input  logic [REG_W-1:0] wb_addr,
  input  logic             wb_wren,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  data_c
);

  // x0 is hard-wired, so it never takes a forwarded value; the youngest
  // producer (MEM) wins over WB.
  always_comb begin
    data_c = rf_data;
    if (src_addr != REG_ZERO) begin
      if (mem_wren && (mem_addr == src_addr)) begin
        data_c = mem_data;
      end else if (wb_wren && (wb_addr == src_addr)) begin
        data_c = wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register. Holds the decoded instruction, resolves
// operand forwarding from MEM/WB, inserts a bubble on load-use hazards and
// discards the instruction on branch flush. Operands drive the ALU directly.
// Ports: clk_i/rst_i (sync, active-high); valid_i/ready_o/flush_i handshake;
//        decoded fields *_i; MEM/WB forward sources; held fields *_o;
//        stall_cnt_o/flush_cnt_o saturating event counters.
// XLEN must equal pipeline_pkg::XLEN, which sizes the held payload.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN  = pipeline_pkg::XLEN,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [REG_W-1:0]  rs1_addr_i,
  input  logic [REG_W-1:0]  rs2_addr_i,
  input  logic [REG_W-1:0]  rd_addr_i,
  input  logic [OP_W-1:0]   alu_op_i,
  input  logic              op_a_sel_i,
  input  logic              op_b_sel_i,
  input  logic              rd_wren_i,
  input  logic              mem_rden_i,
  input  logic [REG_W-1:0]  mem_rd_addr_i,
  input  logic              mem_rd_wren_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [REG_W-1:0]  wb_rd_addr_i,
  input  logic              wb_rd_wren_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   openrand_a_o,
  output logic [XLEN-1:0]   openrand_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [REG_W-1:0]  rd_addr_o,
  output logic              rd_wren_o,
  output logic              mem_rden_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  id_ex_t           hold_q;
  id_ex_t           hold_in;
  logic             hazard_c;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [XLEN-1:0]  fwd_rs1;
  logic [XLEN-1:0]  fwd_rs2;

  // Load-use: the held load's result is not ready until it reaches MEM.
  // Both source indices are compared even if the consumer ignores one.
  always_comb begin
    hazard_c = hold_q.valid && hold_q.mem_rden && (hold_q.rd_addr != REG_ZERO) &&
               valid_i && ((rs1_addr_i == hold_q.rd_addr) || (rs2_addr_i == hold_q.rd_addr));
  end

  assign ready_o = ~hazard_c;

  // Pack the incoming decode fields.
  always_comb begin
    hold_in          = '0;
    hold_in.valid    = valid_i;
    hold_in.pc       = pc_i;
    hold_in.imm      = imm_i;
    hold_in.rs1_data = rs1_data_i;
    hold_in.rs2_data = rs2_data_i;
    hold_in.rs1_addr = rs1_addr_i;
    hold_in.rs2_addr = rs2_addr_i;
    hold_in.rd_addr  = rd_addr_i;
    hold_in.alu_op   = alu_op_e'(alu_op_i);
    hold_in.op_a_sel = op_a_sel_i;
    hold_in.op_b_sel = op_b_sel_i;
    hold_in.rd_wren  = rd_wren_i;
    hold_in.mem_rden = mem_rden_i;
  end

  // Held instruction: reset > flush > bubble > load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else if (flush_i || hazard_c) begin
      hold_q.valid <= 1'b0;
    end else begin
      hold_q <= hold_in;
    end
  end

  // Event counters saturate at all-ones; flush suppresses the stall count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (flush_i) begin
      if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end else if (hazard_c) begin
      if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .src_addr (hold_q.rs1_addr),
    .rf_data  (hold_q.rs1_data),
    .mem_addr (mem_rd_addr_i),
    .mem_wren (mem_rd_wren_i),
    .mem_data (mem_data_i),
    .wb_addr  (wb_rd_addr_i),
    .wb_wren  (wb_rd_wren_i),
    .wb_data  (wb_data_i),
    .data_c   (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .src_addr (hold_q.rs2_addr),
    .rf_data  (hold_q.rs2_data),
    .mem_addr (mem_rd_addr_i),
    .mem_wren (mem_rd_wren_i),
    .mem_data (mem_data_i),
    .wb_addr  (wb_rd_addr_i),
    .wb_wren  (wb_rd_wren_i),
    .wb_data  (wb_data_i),
    .data_c   (fwd_rs2)
  );

  // ALU-facing outputs; control side effects are masked for bubbles.
  assign valid_o      = hold_q.valid;
  assign openrand_a_o = hold_q.op_a_sel ? hold_q.pc  : fwd_rs1;
  assign openrand_b_o = hold_q.op_b_sel ? hold_q.imm : fwd_rs2;
  assign store_data_o = fwd_rs2;
  assign alu_op_o     = hold_q.valid ? OP_W'(hold_q.alu_op) : OP_W'(ALU_ADD);
  assign pc_o         = hold_q.pc;
  assign rd_addr_o    = hold_q.rd_addr;
  assign rd_wren_o    = hold_q.valid & hold_q.rd_wren;
  assign mem_rden_o   = hold_q.valid & hold_q.mem_rden;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: a vector table for forwarding
// and operand selection, plus hand sequences for load-use, flush, reset and
// counter saturation. Counters are narrowed to keep saturation short.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i, flush_i;
  logic             ready_o;
  logic [XLEN-1:0]  pc_i, imm_i, rs1_data_i, rs2_data_i;
  logic [4:0]       rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [3:0]       alu_op_i;
  logic             op_a_sel_i, op_b_sel_i, rd_wren_i, mem_rden_i;
  logic [4:0]       mem_rd_addr_i, wb_rd_addr_i;
  logic             mem_rd_wren_i, wb_rd_wren_i;
  logic [XLEN-1:0]  mem_data_i, wb_data_i;
  logic             valid_o, rd_wren_o, mem_rden_o;
  logic [XLEN-1:0]  openrand_a_o, openrand_b_o, store_data_o, pc_o;
  logic [3:0]       alu_op_o;
  logic [4:0]       rd_addr_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .pc_i(pc_i), .imm_i(imm_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .alu_op_i(alu_op_i), .op_a_sel_i(op_a_sel_i), .op_b_sel_i(op_b_sel_i),
    .rd_wren_i(rd_wren_i), .mem_rden_i(mem_rden_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_wren_i(mem_rd_wren_i), .mem_data_i(mem_data_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wren_i(wb_rd_wren_i), .wb_data_i(wb_data_i),
    .valid_o(valid_o), .openrand_a_o(openrand_a_o), .openrand_b_o(openrand_b_o),
    .alu_op_o(alu_op_o), .store_data_o(store_data_o), .pc_o(pc_o), .rd_addr_o(rd_addr_o),
    .rd_wren_o(rd_wren_o), .mem_rden_o(mem_rden_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc, imm;
    logic [4:0]  a1;  logic [31:0] d1;
    logic [4:0]  a2;  logic [31:0] d2;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        asel, bsel, rdw;
    logic [4:0]  ma;  logic mw; logic [31:0] md;
    logic [4:0]  wa;  logic ww; logic [31:0] wd;
    logic        ev;
    logic [31:0] ea, eb, es;
    logic [3:0]  eop;
    logic        erdw;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] imm,
                              logic [4:0] a1, logic [31:0] d1, logic [4:0] a2, logic [31:0] d2,
                              logic [4:0] rd, logic [3:0] op, logic asel, logic bsel, logic rdw,
                              logic [4:0] ma, logic mw, logic [31:0] md,
                              logic [4:0] wa, logic ww, logic [31:0] wd,
                              logic ev, logic [31:0] ea, logic [31:0] eb, logic [31:0] es,
                              logic [3:0] eop, logic erdw);
    vec_t t;
    t.v = v; t.pc = pc; t.imm = imm; t.a1 = a1; t.d1 = d1; t.a2 = a2; t.d2 = d2;
    t.rd = rd; t.op = op; t.asel = asel; t.bsel = bsel; t.rdw = rdw;
    t.ma = ma; t.mw = mw; t.md = md; t.wa = wa; t.ww = ww; t.wd = wd;
    t.ev = ev; t.ea = ea; t.eb = eb; t.es = es; t.eop = eop; t.erdw = erdw;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_fwd();
    mem_rd_addr_i = '0; mem_rd_wren_i = 1'b0; mem_data_i = '0;
    wb_rd_addr_i  = '0; wb_rd_wren_i  = 1'b0; wb_data_i  = '0;
  endtask

  // Drive a plain instruction; operand data is derived from the index.
  task automatic set_instr(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] rd, input logic load);
    valid_i = v; pc_i = 32'h40; imm_i = '0;
    rs1_addr_i = a1; rs1_data_i = 32'h1000 + 32'(a1);
    rs2_addr_i = a2; rs2_data_i = 32'h2000 + 32'(a2);
    rd_addr_i = rd; alu_op_i = 4'b0000; op_a_sel_i = 1'b0; op_b_sel_i = 1'b0;
    rd_wren_i = 1'b1; mem_rden_i = load;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = mk(1, 32'h10, 0, 5, 3, 6, 4, 8, 4'b0000, 0, 0, 1,
                 0, 0, 0, 0, 0, 0, 1, 3, 4, 4, 4'b0000, 1);
    vecs[1] = mk(1, 32'h14, 0, 5, 3, 6, 4, 9, 4'b0000, 0, 0, 1,
                 5, 1, 32'hAA, 5, 1, 32'hBB, 1, 32'hAA, 4, 4, 4'b0000, 1);
    vecs[2] = mk(1, 32'h18, 0, 0, 3, 6, 4, 9, 4'b0000, 0, 0, 1,
                 0, 1, 32'hAA, 0, 1, 32'hBB, 1, 3, 4, 4, 4'b0000, 1);
    vecs[3] = mk(1, 32'h1C, 0, 5, 3, 6, 4, 10, 4'b0100, 0, 0, 1,
                 5, 1, 32'hAA, 6, 1, 32'hBB, 1, 32'hAA, 32'hBB, 32'hBB, 4'b0100, 1);
    vecs[4] = mk(1, 32'h20, 0, 5, 3, 6, 4, 11, 4'b0110, 0, 0, 0,
                 5, 0, 32'hAA, 5, 1, 32'hBB, 1, 32'hBB, 4, 4, 4'b0110, 0);
    vecs[5] = mk(1, 32'h100, 32'hFFFFFFFC, 5, 3, 6, 4, 12, 4'b1000, 1, 1, 1,
                 6, 1, 32'h55, 0, 0, 0, 1, 32'h100, 32'hFFFFFFFC, 32'h55, 4'b1000, 1);
    vecs[6] = mk(0, 32'h200, 32'h8, 5, 3, 6, 4, 13, 4'b1000, 0, 1, 1,
                 0, 0, 0, 0, 0, 0, 0, 3, 8, 4, 4'b0000, 0);

    rst_i = 1'b1; flush_i = 1'b0;
    set_instr(1'b0, 0, 0, 0, 1'b0);
    clear_fwd();
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst_valid", 32'(valid_o), 0);
    check("rst_opa", openrand_a_o, 0);
    check("rst_opb", openrand_b_o, 0);
    check("rst_store", store_data_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_aluop", 32'(alu_op_o), 0);
    check("rst_stall", 32'(stall_cnt_o), 0);
    check("rst_flush", 32'(flush_cnt_o), 0);
    check("rst_ready", 32'(ready_o), 1);

    // Vector table: one instruction per cycle, forward sources set in the held cycle.
    for (int i = 0; i < 7; i++) begin
      valid_i = vecs[i].v; pc_i = vecs[i].pc; imm_i = vecs[i].imm;
      rs1_addr_i = vecs[i].a1; rs1_data_i = vecs[i].d1;
      rs2_addr_i = vecs[i].a2; rs2_data_i = vecs[i].d2;
      rd_addr_i = vecs[i].rd; alu_op_i = vecs[i].op;
      op_a_sel_i = vecs[i].asel; op_b_sel_i = vecs[i].bsel;
      rd_wren_i = vecs[i].rdw; mem_rden_i = 1'b0;
      tick();
      mem_rd_addr_i = vecs[i].ma; mem_rd_wren_i = vecs[i].mw; mem_data_i = vecs[i].md;
      wb_rd_addr_i = vecs[i].wa; wb_rd_wren_i = vecs[i].ww; wb_data_i = vecs[i].wd;
      #1;
      check($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vecs[i].ev));
      check($sformatf("v%0d_opa", i), openrand_a_o, vecs[i].ea);
      check($sformatf("v%0d_opb", i), openrand_b_o, vecs[i].eb);
      check($sformatf("v%0d_store", i), store_data_o, vecs[i].es);
      check($sformatf("v%0d_aluop", i), 32'(alu_op_o), 32'(vecs[i].eop));
      check($sformatf("v%0d_rdwren", i), 32'(rd_wren_o), 32'(vecs[i].erdw));
      check($sformatf("v%0d_pc", i), pc_o, vecs[i].pc);
      check($sformatf("v%0d_rd", i), 32'(rd_addr_o), 32'(vecs[i].rd));
      clear_fwd();
    end

    // Load-use: one bubble, then the consumer reads the load result via WB.
    set_instr(1'b1, 1, 2, 7, 1'b1);
    tick();
    check("lu_memrden", 32'(mem_rden_o), 1);
    set_instr(1'b1, 3, 7, 9, 1'b0);
    #1;
    check("lu_ready_low", 32'(ready_o), 0);
    tick();
    check("lu_bubble_valid", 32'(valid_o), 0);
    check("lu_bubble_memrden", 32'(mem_rden_o), 0);
    check("lu_bubble_rdwren", 32'(rd_wren_o), 0);
    check("lu_stall_cnt", 32'(stall_cnt_o), 1);
    check("lu_ready_back", 32'(ready_o), 1);
    tick();
    wb_rd_addr_i = 7; wb_rd_wren_i = 1'b1; wb_data_i = 32'h77;
    #1;
    check("lu_cons_valid", 32'(valid_o), 1);
    check("lu_cons_opb", openrand_b_o, 32'h77);
    check("lu_cons_store", store_data_o, 32'h77);
    check("lu_cons_opa", openrand_a_o, 32'h1003);
    clear_fwd();

    // Flush during a hazard: flush wins, only flush_cnt moves.
    set_instr(1'b1, 1, 2, 7, 1'b1);
    tick();
    set_instr(1'b1, 7, 4, 9, 1'b0);
    flush_i = 1'b1;
    #1;
    check("fl_hazard_seen", 32'(ready_o), 0);
    tick();
    flush_i = 1'b0;
    set_instr(1'b0, 0, 0, 0, 1'b0);
    #1;
    check("fl_valid", 32'(valid_o), 0);
    check("fl_flush_cnt", 32'(flush_cnt_o), 1);
    check("fl_stall_cnt", 32'(stall_cnt_o), 1);

    // Reset asserted mid-stall.
    set_instr(1'b1, 1, 2, 7, 1'b1);
    tick();
    set_instr(1'b1, 7, 7, 9, 1'b0);
    #1;
    check("rs_ready_low", 32'(ready_o), 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("rs_ready_back", 32'(ready_o), 1);
    check("rs_valid", 32'(valid_o), 0);
    check("rs_stall_cnt", 32'(stall_cnt_o), 0);
    check("rs_flush_cnt", 32'(flush_cnt_o), 0);

    // Self-dependent load stream: accept, bubble, accept, bubble ...
    set_instr(1'b1, 7, 0, 7, 1'b1);
    for (int i = 0; i < 2 * 254; i++) tick();
    check("sat_pre", 32'(stall_cnt_o), 254);
    for (int i = 0; i < 2 * 5; i++) tick();
    check("sat_hold", 32'(stall_cnt_o), 32'((1 << CNT_W) - 1));
    check("sat_flush_cnt", 32'(flush_cnt_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
